// File: rtl/csla_64bit_sub_pipe.sv
// 64-bit pipelined subtractor: diff = a - b - bin, one 16-bit carry-select slice per stage.
// Valid/ready on both sides; an empty stage refills even while the output stalls.
module csla_64bit_sub_pipe #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int R0 = WIDTH - SLICE;
   localparam int R1 = WIDTH - 2 * SLICE;
   localparam int R2 = WIDTH - 3 * SLICE;

   // Each group precomputes both carry-in cases; the group carry chain only selects.
   function automatic logic [SLICE:0] csel_slice(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic             cin);
      logic [SLICE-1:0] sum;
      logic [GROUP:0]   s0;
      logic [GROUP:0]   s1;
      logic             c;
      sum = '0;
      c   = cin;
      for (int g = 0; g < SLICE / GROUP; g++) begin
         s0 = {1'b0, x[g*GROUP +: GROUP]} + {1'b0, y[g*GROUP +: GROUP]};
         s1 = {1'b0, x[g*GROUP +: GROUP]} + {1'b0, y[g*GROUP +: GROUP]}
              + {{GROUP{1'b0}}, 1'b1};
         sum[g*GROUP +: GROUP] = c ? s1[GROUP-1:0] : s0[GROUP-1:0];
         c = c ? s1[GROUP] : s0[GROUP];
      end
      return {c, sum};
   endfunction

   logic [3:0]         v_q, v_d;
   logic [3:0]         adv;
   logic [3:0]         ld;

   logic [R0-1:0]      a0_q, a0_d, b0_q, b0_d;
   logic [R1-1:0]      a1_q, a1_d, b1_q, b1_d;
   logic [R2-1:0]      a2_q, a2_d, b2_q, b2_d;
   logic               c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
   logic [SLICE-1:0]   d0_q, d0_d;
   logic [2*SLICE-1:0] d1_q, d1_d;
   logic [3*SLICE-1:0] d2_q, d2_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               bout_q, bout_d;
   logic               ovf_q, ovf_d;

   logic [SLICE:0]     r0, r1, r2, r3;

   always_comb begin
      adv[3] = out_ready | ~v_q[3];
      adv[2] = ~v_q[2] | adv[3];
      adv[1] = ~v_q[1] | adv[2];
      adv[0] = ~v_q[0] | adv[1];

      ld[0] = adv[0] & in_valid;
      ld[1] = adv[1] & v_q[0];
      ld[2] = adv[2] & v_q[1];
      ld[3] = adv[3] & v_q[2];

      v_d[0] = adv[0] ? in_valid : v_q[0];
      v_d[1] = adv[1] ? v_q[0]   : v_q[1];
      v_d[2] = adv[2] ? v_q[1]   : v_q[2];
      v_d[3] = adv[3] ? v_q[2]   : v_q[3];

      // Subtraction as a + ~b + ~bin; the carry out of bit 63 is the inverted borrow.
      r0 = csel_slice(a[SLICE-1:0], ~b[SLICE-1:0], ~bin);
      r1 = csel_slice(a0_q[SLICE-1:0], ~b0_q[SLICE-1:0], c0_q);
      r2 = csel_slice(a1_q[SLICE-1:0], ~b1_q[SLICE-1:0], c1_q);
      r3 = csel_slice(a2_q[SLICE-1:0], ~b2_q[SLICE-1:0], c2_q);

      a0_d = a0_q; b0_d = b0_q; c0_d = c0_q; d0_d = d0_q;
      a1_d = a1_q; b1_d = b1_q; c1_d = c1_q; d1_d = d1_q;
      a2_d = a2_q; b2_d = b2_q; c2_d = c2_q; d2_d = d2_q;
      diff_d = diff_q; bout_d = bout_q; ovf_d = ovf_q;

      if (ld[0]) begin
         a0_d = a[WIDTH-1:SLICE];
         b0_d = b[WIDTH-1:SLICE];
         c0_d = r0[SLICE];
         d0_d = r0[SLICE-1:0];
      end
      if (ld[1]) begin
         a1_d = a0_q[R0-1:SLICE];
         b1_d = b0_q[R0-1:SLICE];
         c1_d = r1[SLICE];
         d1_d = {r1[SLICE-1:0], d0_q};
      end
      if (ld[2]) begin
         a2_d = a1_q[R1-1:SLICE];
         b2_d = b1_q[R1-1:SLICE];
         c2_d = r2[SLICE];
         d2_d = {r2[SLICE-1:0], d1_q};
      end
      if (ld[3]) begin
         diff_d = {r3[SLICE-1:0], d2_q};
         bout_d = ~r3[SLICE];
         ovf_d  = (a2_q[SLICE-1] != b2_q[SLICE-1]) && (r3[SLICE-1] != a2_q[SLICE-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q    <= '0;
         a0_q   <= '0; b0_q <= '0; c0_q <= 1'b0; d0_q <= '0;
         a1_q   <= '0; b1_q <= '0; c1_q <= 1'b0; d1_q <= '0;
         a2_q   <= '0; b2_q <= '0; c2_q <= 1'b0; d2_q <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         v_q    <= v_d;
         a0_q   <= a0_d; b0_q <= b0_d; c0_q <= c0_d; d0_q <= d0_d;
         a1_q   <= a1_d; b1_q <= b1_d; c1_q <= c1_d; d1_q <= d1_d;
         a2_q   <= a2_d; b2_q <= b2_d; c2_q <= c2_d; d2_q <= d2_d;
         diff_q <= diff_d;
         bout_q <= bout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v_q[3];
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/csla_64bit_sub_pipe.md
Name: csla_64bit_sub_pipe

Overview:
- 64-bit subtractor computing diff = a - b - bin, with borrow-out and signed overflow.
- Built as a 4-stage pipeline. Each stage handles one 16-bit slice using a carry-select structure, with both candidate sums precomputed per 4-bit group.
- Valid/ready handshake on both sides. Sits after operand staging and provides the inverse operation to the existing 64-bit carry-select adder, whose stimulus vectors it reuses in reverse.

Parameters:
- WIDTH, 64, operand width; fixed at 64 in this revision; must equal 4*SLICE.
- SLICE, 16, bits resolved per pipeline stage.
- GROUP, 4, carry-select group width inside a slice.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands this cycle.
- a  in  64  minuend.
- b  in  64  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- diff  out  64  a - b - bin, modulo 2^64.
- bout  out  1  borrow-out; 1 when a < b + bin, unsigned.
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Arithmetic:
  - diff = a + ~b + cin, with cin = ~bin.
  - bout = ~carry_out of bit 63.
  - ovf = (a[63] != b[63]) && (diff[63] != a[63]).
- Stage k (k = 0..3):
  - Resolves bits [16k+15:16k] from the incoming carry.
  - Within the slice, each 4-bit group precomputes sum0/sum1 and selects on the ripple of group carries.
  - Carry registered into stage k+1.
  - Unprocessed operand bits and completed diff bits travel with the stage.
- Each stage holds a valid bit v[k].
  - Stage k loads when v[k] = 0 or stage k+1 accepts (advance[k]).
  - Stage 3 advances when out_ready = 1 or v[3] = 0.
- Outputs:
  - in_ready = advance[0], combinational from the valid bits and out_ready; no skid buffer.
  - Transfer in: in_valid && in_ready.
  - Transfer out: out_valid && out_ready.
  - out_valid = v[3]; diff, bout and ovf come from stage 3 registers.
- Latency: exactly 4 cycles from input transfer to out_valid with no backpressure. Throughput is 1 per cycle.
- Stall:
  - While out_valid = 1 and out_ready = 0, diff/bout/ovf hold stable.
  - Bubbles upstream still compress: an empty stage fills even while stage 3 stalls.
  - in_ready drops only when all 4 stages are full and out_ready = 0.
- Simultaneous input and output transfer in the same cycle is legal when full; occupancy stays unchanged.
- Reset (rst_n = 0 at a clock edge):
  - All v[k] = 0, out_valid = 0, diff = 0, bout = 0, ovf = 0.
  - Data registers clear; carries clear.
  - In-flight operations are discarded with no partial output.
  - in_ready = 1 in the first cycle after reset release.
- Operand ordering: results emerge strictly in input order; no reordering, no drops.
- Data registers load only on an accepted transfer, never when in_valid = 0.

Test Plan:
- Single op, a=56, b=48, bin=0, out_ready=1 -> out_valid at cycle +4; diff=8, bout=0, ovf=0.
- Back-to-back ops (139-123-1; 13921-9537-0; 4012345-3456789-1) -> diff 15, 4384, 555555 on consecutive cycles 4..6; bout=0.
- Wrap: a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0. Also a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, bout=0, ovf=1.
- Backpressure: stream 6 ops with out_ready held 0 -> in_ready falls after 4 accepts and the first result holds stable. Release out_ready -> all 6 results emerge in order, none lost or duplicated.
- Cross-slice borrow: a=0x0001_0000_0000_0000, b=1, bin=1 -> diff=0x0000_FFFF_FFFF_FFFE, bout=0. The borrow propagates through stages 0-2.
- Reset mid-operation: 3 ops in flight, then rst_n=0 for 1 cycle -> no out_valid for those ops; outputs read 0; next op after release completes with latency 4.
